// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl
//   Dispenser-side controller for the vending machine. It accepts a dispense
//   request with a product code and credit. It drives a one-hot motor select
//   for a fixed on-time, then waits for the product-drop sensor. It reports
//   done/reject/fault and the change owed.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   d          dispense request (sampled only in IDLE)
//   p          product code, 0 invalid, price of product k = k units
//   c          credit held at request time
//   drop_sns   product-fell sensor (level)
//   fault_clr  operator clear, leaves FAULT
//   motor      one-hot motor select (bit p while running)
//   busy       high in RUN, WAIT_DROP, DONE, FAULT
//   done       1-cycle pulse on successful dispense
//   reject     1-cycle pulse on refused request
//   change     c - p, valid with change_vld, holds otherwise
//   change_vld 1-cycle pulse coincident with done
//   fault      level, high while in FAULT
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [2:0] p,
  input  logic [2:0] c,
  input  logic       drop_sns,
  input  logic       fault_clr,
  output logic [7:0] motor,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic [2:0] change,
  output logic       change_vld,
  output logic       fault
);

  localparam int CW = $clog2(MOTOR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RUN, WAIT_DROP, DONE, FAULT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [2:0]    p_r, c_r;
  logic          drop_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tmr        <= '0;
      p_r        <= '0;
      c_r        <= '0;
      drop_seen  <= 1'b0;
      motor      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reject     <= 1'b0;
      change     <= '0;
      change_vld <= 1'b0;
      fault      <= 1'b0;
    end else begin
      // Pulse outputs default low; the state that owns them raises them.
      done       <= 1'b0;
      reject     <= 1'b0;
      change_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (d) begin
            p_r <= p;
            c_r <= c;
            if (p == 3'd0 || c < p) begin
              reject <= 1'b1;
            end else begin
              state     <= RUN;
              motor     <= 8'b1 << p;
              busy      <= 1'b1;
              cnt       <= CW'(MOTOR_CYCLES - 1);
              drop_seen <= 1'b0;
            end
          end
        end
        RUN: begin
          // An early drop (while the motor is still turning) is remembered
          // so WAIT_DROP can finish at once.
          if (drop_sns) drop_seen <= 1'b1;
          if (cnt == '0) begin
            state <= WAIT_DROP;
            motor <= '0;
            tmr   <= TW'(TIMEOUT_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_DROP: begin
          // Drop is tested before the timeout so a coincident drop wins.
          if (drop_sns || drop_seen) begin
            state      <= DONE;
            done       <= 1'b1;
            change_vld <= 1'b1;
            change     <= c_r - p_r;
          end else if (tmr == '0) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          drop_seen <= 1'b0;
        end
        FAULT: begin
          motor <= '0;
          if (fault_clr) begin
            state     <= IDLE;
            fault     <= 1'b0;
            busy      <= 1'b0;
            drop_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
module tb_vend_dispense_ctrl;
  logic       clk = 1'b0;
  logic       rst, d, drop_sns, fault_clr;
  logic [2:0] p, c;
  logic [7:0] motor;
  logic       busy, done, reject, change_vld, fault;
  logic [2:0] change;

  int checks = 0;
  int errors = 0;

  vend_dispense_ctrl #(.MOTOR_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .d(d), .p(p), .c(c), .drop_sns(drop_sns),
    .fault_clr(fault_clr), .motor(motor), .busy(busy), .done(done),
    .reject(reject), .change(change), .change_vld(change_vld), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles the motor stays on (bounded); drop_sns pulsed at index drop_at.
  task automatic run_motor(input int drop_at, output int n);
    n = 0;
    while (motor != 8'd0 && n < 40) begin
      drop_sns = (n == drop_at);
      tick();
      n++;
    end
    drop_sns = 1'b0;
  endtask

  int n, w, bad;

  initial begin
    rst = 1'b1; d = 0; p = 0; c = 0; drop_sns = 0; fault_clr = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_motor", motor, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, reject, change_vld, fault}, 0);
    chk("rst_change", change, 0);

    // 1: p=3 c=5, drop two cycles after motor stops
    p = 3; c = 5; d = 1; tick(); d = 0; p = 0; c = 0;
    chk("t1_motor", motor, 8'h08);
    chk("t1_busy", busy, 1);
    run_motor(-1, n);
    chk("t1_motor_len", n, 8);
    tick();
    drop_sns = 1; tick(); drop_sns = 0;
    chk("t1_done", {done, change_vld}, 3);
    chk("t1_change", change, 2);
    tick();
    chk("t1_busy_fall", busy, 0);
    chk("t1_done_fall", {done, change_vld}, 0);
    chk("t1_change_hold", change, 2);

    // 2: rejects
    p = 5; c = 2; d = 1; tick(); d = 0;
    chk("t2a_reject", reject, 1);
    chk("t2a_idle", {motor, busy}, 0);
    tick();
    chk("t2a_reject_fall", {reject, busy}, 0);
    p = 0; c = 7; d = 1; tick(); d = 0;
    chk("t2b_reject", reject, 1);
    chk("t2b_idle", {motor, busy}, 0);
    tick();

    // 3: timeout fault, d ignored, fault_clr
    p = 1; c = 1; d = 1; tick(); d = 0;
    chk("t3_motor", motor, 8'h02);
    run_motor(-1, n);
    chk("t3_motor_len", n, 8);
    w = 0;
    while (!fault && w < 100) begin tick(); w++; end
    chk("t3_wait_len", w, 16);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      d = (i % 3 == 0); p = 2; c = 7;
      tick();
      if (!fault || motor != 0 || !busy || change_vld || done) bad++;
    end
    d = 0;
    chk("t3_fault_hold", bad, 0);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("t3_fault_clr", {fault, busy, change_vld}, 0);
    tick();
    chk("t3_idle", {motor, busy}, 0);

    // 4: drop seen during RUN only
    p = 7; c = 7; d = 1; tick(); d = 0;
    chk("t4_motor", motor, 8'h80);
    run_motor(3, n);
    chk("t4_motor_len", n, 8);
    tick();
    chk("t4_done", {done, change_vld}, 3);
    chk("t4_change", change, 0);
    tick();

    // 5: reset on 4th motor cycle, then normal request
    p = 2; c = 4; d = 1; tick(); d = 0;
    tick(); tick(); tick();
    chk("t5_motor_4th", motor, 8'h04);
    rst = 1; tick(); rst = 0;
    chk("t5_rst_motor", {motor, busy}, 0);
    chk("t5_rst_pulse", {done, change_vld}, 0);
    p = 4; c = 6; d = 1; tick(); d = 0;
    chk("t5_motor", motor, 8'h10);
    run_motor(-1, n);
    chk("t5_motor_len", n, 8);
    drop_sns = 1; tick(); drop_sns = 0;
    chk("t5_done", {done, change_vld}, 3);
    chk("t5_change", change, 2);
    tick();

    // 6: d held high, drop coincides with timeout edge
    p = 2; c = 3; d = 1; tick();
    chk("t6_motor", motor, 8'h04);
    run_motor(-1, n);
    repeat (15) tick();
    chk("t6_no_fault_yet", fault, 0);
    drop_sns = 1; tick(); drop_sns = 0;
    chk("t6_done", {done, change_vld, fault}, 6);
    chk("t6_change", change, 1);
    tick();
    chk("t6_idle", {motor, busy}, 0);
    tick();
    chk("t6_restart", {motor, busy}, {8'h04, 1'b1});
    d = 0;
    run_motor(-1, n);
    chk("t6_motor_len2", n, 8);
    drop_sns = 1; tick(); drop_sns = 0;
    chk("t6_done2", {done, change}, {1'b1, 3'd1});
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
